// File: rtl/bitstream_bit_reader.sv
// MSB-first bit reader between a byte source and the CABAC engine.
// Define BIT_READER_ZERO_PAD_EN to zero-pad reads past end of stream instead of erroring.
module bitstream_bit_reader #(
  parameter int unsigned MAX_BITS = 16,
  parameter int unsigned BUF_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          data_i,
  input  logic                data_ready_i,
  output logic                request_o,
  input  logic                rd_req_i,
  input  logic [4:0]          rd_nbits_i,
  input  logic                rd_align_i,
  output logic                rd_ready_o,
  output logic                rd_valid_o,
  output logic [MAX_BITS-1:0] rd_data_o,
  output logic                rd_eos_o,
  output logic                rd_err_o,
  output logic [31:0]         bit_count_o
);

  localparam int unsigned FillW = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

  state_e              state_q, state_d;
  logic [BUF_W-1:0]    buf_q, buf_d;
  logic [FillW-1:0]    fill_q, fill_d;
  logic [4:0]          nbits_q, nbits_d;
  logic                rd_valid_q, rd_valid_d;
  logic [MAX_BITS-1:0] rd_data_q, rd_data_d;
  logic                eos_q, eos_d;
  logic                err_q, err_d;
  logic [31:0]         bit_count_q, bit_count_d;

  logic [4:0]       req_n;
  logic [2:0]       align_n;
  logic             serve;
  logic [4:0]       serve_n;
  logic [FillW-1:0] cons_n;
  logic [4:0]       bc_inc;
  logic [BUF_W-1:0] peek;
  logic [BUF_W-1:0] buf_shift;
  logic [FillW-1:0] fill_post;
  logic [BUF_W-1:0] byte_al;

  assign req_n   = (rd_nbits_i > 5'(MAX_BITS)) ? 5'(MAX_BITS) : rd_nbits_i;
  // Distance to the next byte boundary; the buffer always holds at least this many bits.
  assign align_n = 3'd0 - bit_count_q[2:0];

  assign request_o  = !rst_i && data_ready_i && (fill_q <= FillW'(BUF_W - 8)) &&
                      (state_q != StErr);
  assign rd_ready_o = !rst_i && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    nbits_d = nbits_q;
    eos_d   = eos_q;
    err_d   = err_q;
    serve   = 1'b0;
    serve_n = 5'd0;
    cons_n  = '0;
    bc_inc  = 5'd0;
    unique case (state_q)
      StIdle: begin
        if (rd_align_i) begin
          serve  = 1'b1;
          cons_n = FillW'(align_n);
          bc_inc = 5'(align_n);
        end else if (rd_req_i) begin
          if (FillW'(req_n) <= fill_q) begin
            serve   = 1'b1;
            serve_n = req_n;
            cons_n  = FillW'(req_n);
            bc_inc  = req_n;
          end else begin
            state_d = StWait;
            nbits_d = req_n;
          end
        end
      end
      StWait: begin
        if (FillW'(nbits_q) <= fill_q) begin
          serve   = 1'b1;
          serve_n = nbits_q;
          cons_n  = FillW'(nbits_q);
          bc_inc  = nbits_q;
          state_d = StIdle;
        end else if (!data_ready_i) begin
`ifdef BIT_READER_ZERO_PAD_EN
          // Bits below fill are already zero, so the peek supplies the padding.
          serve   = 1'b1;
          serve_n = nbits_q;
          cons_n  = fill_q;
          bc_inc  = nbits_q;
          eos_d   = 1'b1;
          state_d = StIdle;
`else
          err_d   = 1'b1;
          state_d = StErr;
`endif
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    peek      = buf_q >> (FillW'(BUF_W) - FillW'(serve_n));
    buf_shift = buf_q << cons_n;
    fill_post = fill_q - cons_n;
    byte_al   = {data_i, {(BUF_W - 8){1'b0}}} >> fill_post;
    if (request_o) begin
      buf_d  = buf_shift | byte_al;
      fill_d = fill_post + FillW'(8);
    end else begin
      buf_d  = buf_shift;
      fill_d = fill_post;
    end
    rd_valid_d  = serve;
    rd_data_d   = rd_data_q;
    if (serve) begin
      rd_data_d = (serve_n == 5'd0) ? '0 : peek[MAX_BITS-1:0];
    end
    bit_count_d = bit_count_q + 32'(bc_inc);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      fill_q      <= '0;
      nbits_q     <= 5'd0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      eos_q       <= 1'b0;
      err_q       <= 1'b0;
      bit_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      nbits_q     <= nbits_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      eos_q       <= eos_d;
      err_q       <= err_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_eos_o    = eos_q;
  assign rd_err_o    = err_q;
  assign bit_count_o = bit_count_q;

endmodule

// File: tb/tb_bitstream_bit_reader.sv
// Scoreboard bench for bitstream_bit_reader: directed reads, a byte-source model and a monitor.
module tb_bitstream_bit_reader;

  localparam int MaxBits = 16;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [7:0]         data_i;
  logic               data_ready_i;
  logic               request_o;
  logic               rd_req_i;
  logic [4:0]         rd_nbits_i;
  logic               rd_align_i;
  logic               rd_ready_o;
  logic               rd_valid_o;
  logic [MaxBits-1:0] rd_data_o;
  logic               rd_eos_o;
  logic               rd_err_o;
  logic [31:0]        bit_count_o;

  always #5 clk_i = ~clk_i;

  bitstream_bit_reader #(
    .MAX_BITS(MaxBits),
    .BUF_W   (32)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .data_ready_i(data_ready_i),
    .request_o   (request_o),
    .rd_req_i    (rd_req_i),
    .rd_nbits_i  (rd_nbits_i),
    .rd_align_i  (rd_align_i),
    .rd_ready_o  (rd_ready_o),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .rd_eos_o    (rd_eos_o),
    .rd_err_o    (rd_err_o),
    .bit_count_o (bit_count_o)
  );

  typedef struct {
    logic [MaxBits-1:0] data;
    logic [31:0]        bc;
    logic               eos;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_q[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_bc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  // Byte source: pops on the edge where request was high, presents next byte after.
  initial begin : source
    logic took;
    data_i       = 8'h00;
    data_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      took = request_o;
      @(negedge clk_i);
      if (took && src_q.size() > 0) void'(src_q.pop_front());
      data_ready_i = (src_q.size() > 0);
      data_i       = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
  end

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (rd_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got rd_data 0x%0h, required no pulse", rd_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(rd_data_o), 32'(e.data));
        chk("bit_count", bit_count_o, e.bc);
        chk("rd_eos", 32'(rd_eos_o), 32'(e.eos));
      end
    end
  end

  task automatic wait_ready(input string name);
    int cnt = 0;
    while (rd_ready_o !== 1'b1 && cnt < 100) begin
      @(negedge clk_i);
      cnt++;
    end
    if (cnt >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got rd_ready 0, required 1 within 100 cycles", name);
    end
  endtask

  task automatic do_read(input int n, input logic [MaxBits-1:0] d, input bit expect_rsp,
                         input bit eos);
    exp_t e;
    int nc = (n > MaxBits) ? MaxBits : n;
    if (expect_rsp) begin
      exp_bc += nc;
      e.data = d;
      e.bc   = 32'(exp_bc);
      e.eos  = eos;
      exp_q.push_back(e);
    end
    rd_nbits_i = 5'(n);
    rd_req_i   = 1'b1;
    wait_ready("read");
    @(negedge clk_i);
    rd_req_i = 1'b0;
  endtask

  task automatic do_align();
    exp_t e;
    exp_bc += (8 - (exp_bc % 8)) % 8;
    e.data = '0;
    e.bc   = 32'(exp_bc);
    e.eos  = 1'b0;
    exp_q.push_back(e);
    rd_align_i = 1'b1;
    wait_ready("align");
    @(negedge clk_i);
    rd_align_i = 1'b0;
  endtask

  task automatic drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 60) begin
      @(negedge clk_i);
      cnt++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d responses pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rd_req_i   = 1'b0;
    rd_align_i = 1'b0;
    rst_i      = 1'b1;
    src_q.delete();
    exp_bc = 0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_ready"}, 32'(rd_ready_o), 32'd0);
    chk({tag, "_request"}, 32'(request_o), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid_o), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data_o), 32'd0);
    chk({tag, "_bit_count"}, bit_count_o, 32'd0);
    chk({tag, "_rd_eos"}, 32'(rd_eos_o), 32'd0);
    chk({tag, "_rd_err"}, 32'(rd_err_o), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] pat;
    rst_i      = 1'b1;
    rd_req_i   = 1'b0;
    rd_align_i = 1'b0;
    rd_nbits_i = 5'd0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");

    // Basic reads and alignment.
    src_q.push_back(8'hA5);
    src_q.push_back(8'h3C);
    rst_i = 1'b0;
    #1;
    chk("rd_ready_after_reset", 32'(rd_ready_o), 32'd1);
    repeat (4) @(negedge clk_i);
    do_read(4, 16'h000A, 1'b1, 1'b0);
    do_read(9, 16'h00A7, 1'b1, 1'b0);
    do_align();
    do_align();
    drain();

    // Sixteen single-bit reads.
    do_reset();
    src_q.push_back(8'hA5);
    src_q.push_back(8'h3C);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
    pat = 16'hA53C;
    for (int i = 0; i < 16; i++) do_read(1, 16'(pat[15-i]), 1'b1, 1'b0);
    drain();

    // Read 16 straight after reset: miss then serve.
    do_reset();
    src_q.push_back(8'h12);
    src_q.push_back(8'h34);
    rst_i = 1'b0;
    do_read(16, 16'h1234, 1'b1, 1'b0);
    drain();

    // Clamp above MAX_BITS, zero-length read, then a byte.
    do_reset();
    src_q.push_back(8'hC3);
    src_q.push_back(8'h96);
    src_q.push_back(8'hF0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
    do_read(31, 16'hC396, 1'b1, 1'b0);
    do_read(0, 16'h0000, 1'b1, 1'b0);
    do_read(8, 16'h00F0, 1'b1, 1'b0);
    drain();

    // End of stream.
    do_reset();
    src_q.push_back(8'hFF);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
`ifdef BIT_READER_ZERO_PAD_EN
    do_read(12, 16'h0FF0, 1'b1, 1'b1);
    do_read(8, 16'h0000, 1'b1, 1'b1);
    drain();
    chk("eos_rd_err", 32'(rd_err_o), 32'd0);
`else
    do_read(12, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    chk("err_rd_err", 32'(rd_err_o), 32'd1);
    chk("err_rd_ready", 32'(rd_ready_o), 32'd0);
    chk("err_request", 32'(request_o), 32'd0);
    chk("err_bit_count", bit_count_o, 32'd0);
    chk("err_rd_eos", 32'(rd_eos_o), 32'd0);
    src_q.push_back(8'h55);
    repeat (2) @(negedge clk_i);
    chk("err_request_with_data", 32'(request_o), 32'd0);
`endif

    // Reset during WAIT aborts the read.
    do_reset();
    src_q.push_back(8'h5A);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    do_read(16, 16'h0000, 1'b0, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("abort");
    src_q.push_back(8'h77);
    @(negedge clk_i);
    rst_i = 1'b0;
    do_read(8, 16'h0077, 1'b1, 1'b0);
    drain();

    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
